// File: rtl/sweep_pkg.sv
// sweep_pkg: shared state encoding and vector-count helpers for the sweep benches
package sweep_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

    localparam int N_IN_DEF  = 4;
    localparam int N_VEC_DEF = 2 ** N_IN_DEF;

    function automatic int vec_count(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// sweep_counter: vector index with load-zero, increment and last-vector flag
module sweep_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] idx,
    output logic         last
);

    // load has priority so an abort or a fresh start always lands on vector 0
    always_ff @(posedge clk or posedge rst)
        if (rst) idx <= '0;
        else if (load) idx <= '0;
        else if (inc) idx <= idx + W'(1);

    assign last = &idx;

endmodule

// File: rtl/exhaustive_sweep_checker.sv
// exhaustive_sweep_checker: drives every input vector to a combinational DUT and checks it against a latched truth table
module exhaustive_sweep_checker
    import sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   exp_tt,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_idx
);

    localparam int N_VEC = vec_count(N_IN);
    localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t           state, state_next;
    logic [N_VEC-1:0] tt;
    logic [SW-1:0]    settle_cnt;
    logic             load, inc, last, miss, settle_end;

    sweep_counter #(.W(N_IN)) u_cnt (
        .clk (clk),
        .rst (rst),
        .load(load),
        .inc (inc),
        .idx (dut_in),
        .last(last)
    );

    assign miss       = (state == ST_SAMPLE) && (dut_out != tt[dut_in]);
    assign settle_end = settle_cnt == SW'(SETTLE - 1);
    assign busy       = state != ST_IDLE;
    assign done       = state == ST_DONE;

    // next-state and counter control; with SETTLE=0 the settle state is skipped entirely
    always_comb begin
        state_next = state;
        load       = 1'b0;
        inc        = 1'b0;
        case (state)
            ST_IDLE:
                if (start && !abort) begin
                    load       = 1'b1;
                    state_next = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            ST_SETTLE:
                if (abort) begin
                    load       = 1'b1;
                    state_next = ST_IDLE;
                end else if (settle_end) state_next = ST_SAMPLE;
            ST_SAMPLE:
                if (abort) begin
                    load       = 1'b1;
                    state_next = ST_IDLE;
                end else if (last) state_next = ST_DONE;
                else begin
                    inc        = 1'b1;
                    state_next = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            default: state_next = ST_IDLE;
        endcase
    end

    // state, latched table and result registers; an aborted sample is not scored
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= ST_IDLE;
            tt            <= '0;
            settle_cnt    <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            pass          <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= (state == ST_SETTLE && !settle_end) ? settle_cnt + SW'(1) : '0;
            if (state == ST_IDLE && load) begin
                tt            <= exp_tt;
                err_count     <= '0;
                first_err_idx <= '0;
                pass          <= 1'b0;
            end
            if (miss && !abort) begin
                err_count <= err_count + (N_IN + 1)'(1);
                if (err_count == '0) first_err_idx <= dut_in;
            end
            if (state == ST_SAMPLE && state_next == ST_DONE) pass <= (err_count == '0) && !miss;
        end

endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// tb_exhaustive_sweep_checker: scoreboard bench driving a gate-level F = A(CD+B) + BC' through the sweep engine
module tb_exhaustive_sweep_checker;

    logic        clk = 0, rst = 1, start = 0, abort = 0, dut_out;
    logic [15:0] exp_tt = '0;
    logic [3:0]  dut_in, first_err_idx;
    logic [4:0]  err_count;
    logic        busy, done, pass;

    typedef struct { int pass; int err; int first; } res_t;
    res_t sb[$];
    int tests = 0, fails = 0;

    exhaustive_sweep_checker #(.N_IN(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tt(exp_tt),
        .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    function automatic logic gate_f(input logic [3:0] v);
        return (v[3] & ((v[1] & v[0]) | v[2])) | (v[2] & ~v[1]);
    endfunction

    assign dut_out = gate_f(dut_in);

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".dut_in"}, dut_in, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".pass"}, pass, 0);
        chk({tag, ".err"}, err_count, 0);
        chk({tag, ".first"}, first_err_idx, 0);
    endtask

    // run one sweep; abort_at/restart_at are vector numbers, rst_at a cycle number, -1 for none
    task automatic sweep(input logic [15:0] tt, input int abort_at, input int restart_at, input int rst_at);
        res_t e, got;
        int   part = 0, part_first = 0;
        bit   seen = 0;
        e.err = 0; e.first = 0;
        for (int i = 15; i >= 0; i--)
            if (gate_f(4'(i)) != tt[i]) begin
                e.err++;
                e.first = i;
            end
        for (int i = abort_at - 1; i >= 0; i--)
            if (gate_f(4'(i)) != tt[i]) begin
                part++;
                part_first = i;
            end
        e.pass = (e.err == 0);
        sb.push_back(e);
        @(negedge clk);
        exp_tt = tt;
        start  = 1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                start  = 0;
                exp_tt = ~tt;
            end
            if (restart_at >= 0 && n == 2 * restart_at + 1) start = 1;
            if (restart_at >= 0 && n == 2 * restart_at + 2) start = 0;
            if (n <= 33) chk("dut_in", dut_in, n <= 32 ? (n - 1) / 2 : 15);
            chk("busy", busy, n <= 33);
            if (rst_at >= 0 && n == rst_at) begin
                #3 rst = 1;
                #1 chk_zero("async_rst");
                @(negedge clk) rst = 0;
                void'(sb.pop_front());
                return;
            end
            if (abort_at >= 0 && n == 2 * abort_at + 1) begin
                abort = 1;
                @(posedge clk);
                #1 abort = 0;
                chk("abort.dut_in", dut_in, 0);
                chk("abort.busy", busy, 0);
                chk("abort.done", done, 0);
                chk("abort.pass", pass, 0);
                chk("abort.err", err_count, part);
                if (part != 0) chk("abort.first", first_err_idx, part_first);
                void'(sb.pop_front());
                return;
            end
            if (done) begin
                got = sb.pop_front();
                seen = 1;
                chk("done_cycle", n, 33);
                chk("pass", pass, got.pass);
                chk("err_count", err_count, got.err);
                if (got.err != 0) chk("first_err_idx", first_err_idx, got.first);
                @(posedge clk);
                #1;
                chk("done_pulse", done, 0);
                chk("idle.busy", busy, 0);
                chk("hold.dut_in", dut_in, 15);
                chk("hold.err", err_count, got.err);
                chk("hold.pass", pass, got.pass);
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #12;
        chk_zero("reset");
        @(negedge clk) rst = 0;
        sweep(16'hF830, -1, -1, -1);
        sweep(16'hF831, -1, -1, -1);
        sweep(16'h07CF, -1, -1, -1);
        sweep(16'h1830, -1, -1, -1);
        sweep(16'hF831, 6, -1, -1);
        sweep(16'hF830, -1, -1, 10);
        sweep(16'hF830, -1, -1, -1);
        sweep(16'hF830, -1, 3, -1);
        @(negedge clk);
        abort = 1;
        start = 1;
        @(negedge clk);
        abort = 0;
        start = 0;
        chk("abort_start.busy", busy, 0);
        chk("abort_start.pass", pass, 1);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("idle_abort.pass", pass, 1);
        chk("idle_abort.dut_in", dut_in, 15);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
